// File: rtl/fpu_out_pkg.sv
// fpu_out_pkg: shared field positions, defaults and
// sizing helpers for the FPU CPX output arbiter.
package fpu_out_pkg;

  localparam int NDEST_DEF = 8;
  localparam int DW_DEF    = 145;

  // ID = {dest one-hot, thread[1:0]}
  localparam int THR_LSB  = 0;
  localparam int THR_W    = 2;
  localparam int DEST_LSB = THR_LSB + THR_W;

  function automatic int dest_msb(input int ndest);
    return DEST_LSB + ndest - 1;
  endfunction

  function automatic int cred_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/fpu_out_fifo.sv
// fpu_out_fifo: small synchronous FIFO holding one pipe's
// {id, payload} results until the arbiter grants them.
module fpu_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  assign rdata = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpu_out_arb.sv
// fpu_out_arb: per-pipe result FIFOs, RR/fixed arbiter,
// CPX credit counter and registered cq/ca output stages.
module fpu_out_arb
  import fpu_out_pkg::*;
#(
  parameter int NPIPE   = 3,
  parameter int NDEST   = NDEST_DEF,
  parameter int DW      = DW_DEF,
  parameter int IDW     = NDEST + 2,
  parameter int DEPTH   = 2,
  parameter int CREDITS = 2
) (
  input  logic                 rclk,
  input  logic                 grst,
  input  logic [NPIPE-1:0]     pipe_vld,
  input  logic [NPIPE*IDW-1:0] pipe_id,
  input  logic [NPIPE*DW-1:0]  pipe_data,
  output logic [NPIPE-1:0]     pipe_rdy,
  input  logic                 prio_mode,
  input  logic                 cpx_credit_ret,
  output logic [NDEST-1:0]     fp_cpx_req_cq,
  output logic [DW-1:0]        fp_cpx_data_ca,
  output logic [NPIPE-1:0]     dest_rdy,
  output logic [1:0]           req_thread,
  output logic                 credit_err
);

  localparam int EW   = IDW + DW;
  localparam int CW   = cred_w(CREDITS);
  localparam int PW   = (NPIPE > 1) ? $clog2(NPIPE) : 1;
  localparam int DMSB = dest_msb(NDEST);

  logic [EW-1:0]    head [NPIPE];
  logic [NPIPE-1:0] full;
  logic [NPIPE-1:0] empty;
  logic [NPIPE-1:0] elig;
  logic [NPIPE-1:0] gnt;
  logic [CW-1:0]    cred;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic [EW-1:0]    sel;
  logic [DW-1:0]    data_s1;
  logic             any;

  assign pipe_rdy = grst ? '0 : ~full;
  assign elig     = (cred != '0) ? ~empty : '0;
  assign any      = |gnt;

  for (genvar i = 0; i < NPIPE; i++) begin : g_fifo
    fpu_out_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk   (rclk),
      .rst   (grst),
      .push  (pipe_vld[i] & pipe_rdy[i]),
      .pop   (gnt[i]),
      .wdata ({pipe_id[i*IDW +: IDW],
               pipe_data[i*DW +: DW]}),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // scan from far to near so the nearest eligible pipe wins
  always_comb begin
    gnt = '0;
    win = '0;
    idx = '0;
    if (prio_mode) begin
      for (int i = NPIPE - 1; i >= 0; i--) begin
        if (elig[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          win    = PW'(i);
        end
      end
    end else begin
      for (int k = NPIPE; k >= 1; k--) begin
        idx = PW'((int'(ptr) + k) % NPIPE);
        if (elig[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          win      = idx;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NPIPE; i++) begin
      if (gnt[i]) sel = head[i];
    end
  end

  always_ff @(posedge rclk) begin
    if (grst) begin
      cred           <= CW'(CREDITS);
      ptr            <= PW'(NPIPE - 1);
      credit_err     <= 1'b0;
      fp_cpx_req_cq  <= '0;
      dest_rdy       <= '0;
      req_thread     <= '0;
      data_s1        <= '0;
      fp_cpx_data_ca <= '0;
    end else begin
      fp_cpx_req_cq  <= sel[DW+DMSB : DW+DEST_LSB];
      req_thread     <= sel[DW+THR_LSB +: THR_W];
      dest_rdy       <= gnt;
      data_s1        <= sel[DW-1:0];
      fp_cpx_data_ca <= data_s1;
      if (any && !prio_mode) ptr <= win;
      if (any && !cpx_credit_ret) begin
        cred <= cred - 1'b1;
      end else if (!any && cpx_credit_ret) begin
        if (cred == CW'(CREDITS)) credit_err <= 1'b1;
        else                      cred <= cred + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_out_arb.sv
// tb_fpu_out_arb: directed scenarios plus random traffic
// checked cycle by cycle against a queue-based model.
module tb_fpu_out_arb;

  localparam int NPIPE   = 3;
  localparam int NDEST   = 8;
  localparam int DW      = 145;
  localparam int IDW     = NDEST + 2;
  localparam int DEPTH   = 2;
  localparam int CREDITS = 2;
  localparam int EW      = IDW + DW;

  logic                 rclk = 1'b0;
  logic                 grst;
  logic [NPIPE-1:0]     pipe_vld;
  logic [NPIPE*IDW-1:0] pipe_id;
  logic [NPIPE*DW-1:0]  pipe_data;
  logic [NPIPE-1:0]     pipe_rdy;
  logic                 prio_mode;
  logic                 cpx_credit_ret;
  logic [NDEST-1:0]     fp_cpx_req_cq;
  logic [DW-1:0]        fp_cpx_data_ca;
  logic [NPIPE-1:0]     dest_rdy;
  logic [1:0]           req_thread;
  logic                 credit_err;

  always #5 rclk = ~rclk;

  fpu_out_arb #(
    .NPIPE   (NPIPE),
    .NDEST   (NDEST),
    .DW      (DW),
    .IDW     (IDW),
    .DEPTH   (DEPTH),
    .CREDITS (CREDITS)
  ) dut (
    .rclk           (rclk),
    .grst           (grst),
    .pipe_vld       (pipe_vld),
    .pipe_id        (pipe_id),
    .pipe_data      (pipe_data),
    .pipe_rdy       (pipe_rdy),
    .prio_mode      (prio_mode),
    .cpx_credit_ret (cpx_credit_ret),
    .fp_cpx_req_cq  (fp_cpx_req_cq),
    .fp_cpx_data_ca (fp_cpx_data_ca),
    .dest_rdy       (dest_rdy),
    .req_thread     (req_thread),
    .credit_err     (credit_err)
  );

  typedef logic [EW-1:0] ent_t;

  ent_t             q [NPIPE][$];
  int               cred;
  int               last;
  bit               err;
  bit               keep = 1'b0;
  bit               chk_on = 1'b0;
  int               total = 0;
  int               bad = 0;
  logic [NDEST-1:0] m_req;
  logic [NPIPE-1:0] m_dst;
  logic [1:0]       m_thr;
  logic [DW-1:0]    m_data;
  logic [DW-1:0]    m_pend;
  logic [NPIPE-1:0] seen [$];

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock of the reference behaviour: grant from the
  // state before this edge, then pop, push and credit update
  task automatic model_step(input logic [NPIPE-1:0] v,
                            input logic m,
                            input logic r,
                            input logic rs);
    int g;
    int p;
    logic [NPIPE-1:0] acc;
    ent_t e;
    if (rs) begin
      foreach (q[i]) q[i].delete();
      cred = CREDITS;
      last = NPIPE - 1;
      err = 1'b0;
      m_req = '0;
      m_dst = '0;
      m_thr = '0;
      m_data = '0;
      m_pend = '0;
      return;
    end
    g = -1;
    if (cred > 0) begin
      for (int k = 0; k < NPIPE; k++) begin
        p = m ? k : (last + 1 + k) % NPIPE;
        if (g < 0 && q[p].size() > 0) g = p;
      end
    end
    m_data = m_pend;
    m_pend = '0;
    m_req = '0;
    m_thr = '0;
    m_dst = '0;
    if (g >= 0) begin
      e = q[g][0];
      m_pend = e[DW-1:0];
      m_req = e[EW-1 -: NDEST];
      m_thr = e[DW+1:DW];
      m_dst[g] = 1'b1;
    end
    for (int i = 0; i < NPIPE; i++)
      acc[i] = v[i] && (q[i].size() < DEPTH);
    if (g >= 0) void'(q[g].pop_front());
    for (int i = 0; i < NPIPE; i++)
      if (acc[i])
        q[i].push_back({pipe_id[i*IDW +: IDW],
                        pipe_data[i*DW +: DW]});
    if (g >= 0 && !r) cred--;
    else if (g < 0 && r) begin
      if (cred == CREDITS) err = 1'b1;
      else cred++;
    end
    if (g >= 0 && !m) last = g;
  endtask

  task automatic step(input logic [NPIPE-1:0] v,
                      input logic m = 1'b0,
                      input logic r = 1'b0,
                      input logic rs = 1'b0);
    logic [NPIPE-1:0] er;
    logic [NDEST-1:0] d;
    pipe_vld = v;
    prio_mode = m;
    cpx_credit_ret = r;
    grst = rs;
    if (!keep) begin
      for (int i = 0; i < NPIPE; i++) begin
        d = '0;
        d[$urandom_range(NDEST-1)] = 1'b1;
        pipe_id[i*IDW +: IDW] = {d, 2'($urandom_range(3))};
        pipe_data[i*DW +: DW] = rnd_data();
      end
    end
    #1;
    for (int i = 0; i < NPIPE; i++)
      er[i] = !rs && (q[i].size() < DEPTH);
    if (chk_on) begin
      chk("req", fp_cpx_req_cq, m_req);
      chk("dst", dest_rdy, m_dst);
      chk("thr", req_thread, m_thr);
      chk("data", fp_cpx_data_ca, m_data);
      chk("rdy", pipe_rdy, er);
      chk("err", credit_err, err);
    end
    if (dest_rdy != '0) seen.push_back(dest_rdy);
    model_step(v, m, r, rs);
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic chk_order(input string tag,
                           input logic [NPIPE-1:0] e [6]);
    chk({tag, "_n"}, seen.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < seen.size()) chk(tag, seen[i], e[i]);
    end
  endtask

  initial begin
    logic [DW-1:0] sd;
    pipe_vld = '0;
    pipe_id = '0;
    pipe_data = '0;
    prio_mode = 1'b0;
    cpx_credit_ret = 1'b0;
    grst = 1'b1;

    step('0, 0, 0, 1);
    chk_on = 1'b1;
    step('0, 0, 0, 1);
    step('0);

    // single result on pipe 1
    keep = 1'b1;
    pipe_id = '0;
    pipe_data = '0;
    pipe_id[1*IDW +: IDW] = {8'h04, 2'd3};
    sd = rnd_data();
    pipe_data[1*DW +: DW] = sd;
    step(3'b010);
    keep = 1'b0;
    step('0);
    chk("single_req", fp_cpx_req_cq, 8'h04);
    chk("single_dst", dest_rdy, 3'b010);
    chk("single_thr", req_thread, 2'd3);
    step('0);
    chk("single_data", fp_cpx_data_ca, sd);
    step('0);
    step('0, 0, 1);
    step('0);

    // round-robin backlog, credits replenished per grant
    step('0, 0, 0, 1);
    seen.delete();
    step(3'b111);
    step(3'b111, 0, 1);
    repeat (5) step('0, 0, 1);
    repeat (3) step('0);
    chk_order("rr", '{3'b001, 3'b010, 3'b100,
                      3'b001, 3'b010, 3'b100});

    // fixed priority on the same backlog
    step('0, 1, 0, 1);
    seen.delete();
    step(3'b111, 1);
    step(3'b111, 1, 1);
    repeat (5) step('0, 1, 1);
    repeat (3) step('0, 1);
    chk_order("fix", '{3'b001, 3'b001, 3'b010,
                       3'b010, 3'b100, 3'b100});

    // credit stall
    step('0, 0, 0, 1);
    seen.delete();
    step(3'b011);
    step(3'b011);
    repeat (5) step('0);
    chk("stall_n", seen.size(), 2);
    step('0, 0, 1);
    step('0);
    chk("stall_ret", dest_rdy != '0, 1'b1);
    repeat (4) step('0);
    chk("stall_n3", seen.size(), 3);

    // back-pressure with credits exhausted
    step('0, 0, 0, 1);
    step(3'b100);
    step(3'b100);
    repeat (3) step('0);
    step(3'b001);
    step(3'b001);
    chk("bp_rdy0", pipe_rdy[0], 1'b0);
    step(3'b001);
    seen.delete();
    step('0, 0, 1);
    step('0);
    step('0, 0, 1);
    repeat (4) step('0);
    chk("bp_n", seen.size(), 2);

    // sticky credit error and mid-traffic reset
    step('0, 0, 0, 1);
    step('0, 0, 1);
    chk("err_set", credit_err, 1'b1);
    repeat (3) step(3'b111);
    chk("err_hold", credit_err, 1'b1);
    step('0, 0, 0, 1);
    chk("rst_req", fp_cpx_req_cq, '0);
    chk("rst_err", credit_err, 1'b0);
    seen.delete();
    repeat (4) step('0);
    chk("rst_stale", seen.size(), 0);

    // random traffic
    repeat (400) begin
      step(NPIPE'($urandom),
           1'($urandom_range(1)),
           $urandom_range(2) == 0,
           $urandom_range(60) == 0);
    end
    repeat (6) step('0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
